// File: rtl/led_stepper.sv
// rtl/led_stepper.sv - one-hot LED position sequencer with debounced button and auto-advance
module led_stepper #(
  parameter int N_LEDS          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_DIV        = 8,
  localparam int POS_W          = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              button,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] leds,
  output logic [POS_W-1:0]  pos,
  output logic              step_pulse
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  typedef enum logic [1:0] {
    MODE_FWD  = 2'b00,
    MODE_REV  = 2'b01,
    MODE_PING = 2'b10,
    MODE_AUTO = 2'b11
  } mode_e;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_LEDS - 1);
  localparam logic [15:0]      DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0]      AUTO_LAST = 24'(AUTO_DIV - 1);

  logic              s1_q, s1_d, s2_q, s2_d;
  logic [15:0]       db_cnt_q, db_cnt_d;
  logic              db_q, db_d, db_prev_q, db_prev_d;
  logic [1:0]        vld_q, vld_d;
  logic              arm_q, arm_d;
  logic [23:0]       auto_cnt_q, auto_cnt_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  dir_e              dir_q, dir_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              step_q, step_d;
  logic              manual_ev, auto_step, step;

  always_comb begin
    s1_d       = button;
    s2_d       = s1_q;
    db_cnt_d   = db_cnt_q;
    db_d       = db_q;
    db_prev_d  = db_q;
    vld_d      = {vld_q[0], 1'b1};
    arm_d      = arm_q;
    auto_cnt_d = auto_cnt_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    auto_step  = 1'b0;

    if (s2_q == db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_d     = s2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 16'd1;
    end

    // A level held through reset must be seen released before a press counts.
    if (vld_q[1] && !s2_q && !db_q) arm_d = 1'b1;
    manual_ev = db_q & ~db_prev_q & arm_q;

    if (mode == MODE_AUTO && we) begin
      if (auto_cnt_q == AUTO_LAST) begin
        auto_cnt_d = '0;
        auto_step  = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + 24'd1;
      end
    end else begin
      auto_cnt_d = '0;
    end

    step   = (mode == MODE_AUTO) ? auto_step : (manual_ev & we);
    step_d = step;

    leds_d         = '0;
    leds_d[pos_q]  = 1'b1;

    if (step && N_LEDS > 1) begin
      case (mode)
        MODE_REV:  pos_d = (pos_q == '0) ? LAST_POS : pos_q - POS_W'(1);
        MODE_PING: begin
          if (dir_q == DIR_UP && pos_q == LAST_POS) begin
            dir_d = DIR_DOWN;
            pos_d = pos_q - POS_W'(1);
          end else if (dir_q == DIR_DOWN && pos_q == '0) begin
            dir_d = DIR_UP;
            pos_d = pos_q + POS_W'(1);
          end else if (dir_q == DIR_UP) begin
            pos_d = pos_q + POS_W'(1);
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
        default:   pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      db_cnt_q   <= '0;
      db_q       <= 1'b0;
      db_prev_q  <= 1'b0;
      vld_q      <= '0;
      arm_q      <= 1'b0;
      auto_cnt_q <= '0;
      pos_q      <= '0;
      dir_q      <= DIR_UP;
      leds_q     <= '0;
      step_q     <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      db_cnt_q   <= db_cnt_d;
      db_q       <= db_d;
      db_prev_q  <= db_prev_d;
      vld_q      <= vld_d;
      arm_q      <= arm_d;
      auto_cnt_q <= auto_cnt_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      leds_q     <= leds_d;
      step_q     <= step_d;
    end
  end

  assign leds       = leds_q;
  assign pos        = pos_q;
  assign step_pulse = step_q;

endmodule

// File: tb/tb_led_stepper.sv
// tb/tb_led_stepper.sv - directed and random checks of led_stepper against a behavioural model
module tb_led_stepper;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int AD = 8;

  logic       clk = 1'b0;
  logic       rst, we, button;
  logic [1:0] mode;
  logic [N-1:0] leds;
  logic [1:0] pos;
  logic       step_pulse;

  led_stepper #(.N_LEDS(N), .DEBOUNCE_CYCLES(D), .AUTO_DIV(AD)) dut (
    .clk(clk), .rst(rst), .we(we), .button(button), .mode(mode),
    .leds(leds), .pos(pos), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;
  int pulses    = 0;
  int cyc       = 0;

  // Behavioural model state
  int m_s1, m_s2, m_db, m_dbp, m_since, m_arm, m_run, m_pos, m_dir, m_leds, m_sp;
  int win[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int ev, stp, flip;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_since = 0; m_arm = 0; m_run = 0;
      m_pos = 0; m_dir = 1; m_leds = 0; m_sp = 0;
      win.delete();
    end else begin
      ev = (m_db == 1 && m_dbp == 0 && m_arm == 1) ? 1 : 0;
      if (mode == 2'b11) begin
        if (we) begin
          m_run++;
          stp = (m_run % AD == 0) ? 1 : 0;
        end else begin
          m_run = 0;
          stp = 0;
        end
      end else begin
        m_run = 0;
        stp = (ev == 1 && we) ? 1 : 0;
      end
      m_leds = 1 << m_pos;
      m_sp = stp;
      if (stp == 1 && N > 1) begin
        if (mode == 2'b01) m_pos = (m_pos + N - 1) % N;
        else if (mode == 2'b10) begin
          if (m_dir == 1 && m_pos == N - 1) begin m_dir = -1; m_pos = m_pos - 1; end
          else if (m_dir == -1 && m_pos == 0) begin m_dir = 1; m_pos = m_pos + 1; end
          else m_pos = m_pos + m_dir;
        end else m_pos = (m_pos + 1) % N;
      end
      if (m_since >= 2 && m_s2 == 0 && m_db == 0) m_arm = 1;
      // db flips once the last D synchronised samples all disagree with it
      win.push_back(m_s2);
      if (win.size() > D) void'(win.pop_front());
      flip = (win.size() == D) ? 1 : 0;
      foreach (win[i]) if (win[i] == m_db) flip = 0;
      m_dbp = m_db;
      if (flip == 1) m_db = 1 - m_db;
      m_s2 = m_s1;
      m_s1 = int'(button);
      if (m_since < 2) m_since++;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    if (step_pulse === 1'b1) pulses++;
    chk("pos", 64'(pos), 64'(m_pos));
    chk("leds", 64'(leds), 64'(m_leds));
    chk("step_pulse", 64'(step_pulse), 64'(m_sp));
  endtask

  task automatic press(input int hold, input int gap);
    button = 1'b1;
    repeat (hold) cycle();
    button = 1'b0;
    repeat (gap) cycle();
  endtask

  initial begin
    int lat, p0, last, first;
    int exp1[4] = '{1, 2, 3, 0};
    int exp3[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int idx[$];

    rst = 1'b1; we = 1'b1; button = 1'b0; mode = 2'b00;
    cycle(); cycle();
    chk("reset_leds", 64'(leds), 64'd0);
    chk("reset_pos", 64'(pos), 64'd0);
    rst = 1'b0;
    cycle();
    chk("first_leds", 64'(leds), 64'd1);
    repeat (3) cycle();

    // 1: forward presses with latency measurement
    lat = -1;
    p0 = int'(pos);
    button = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (lat < 0 && int'(pos) != p0) lat = i - 1;
    end
    button = 1'b0;
    repeat (12) cycle();
    chk("latency", 64'(lat), 64'(D + 2));
    chk("fwd_pos0", 64'(pos), 64'(exp1[0]));
    for (int i = 1; i < 4; i++) begin
      press(10, 12);
      chk("fwd_pos", 64'(pos), 64'(exp1[i]));
      chk("fwd_leds", 64'(leds), 64'(1 << exp1[i]));
    end

    // 2: reverse
    mode = 2'b01;
    press(10, 12);
    chk("rev_pos", 64'(pos), 64'd3);
    chk("rev_leds", 64'(leds), 64'h8);
    press(10, 12);
    chk("rev_pos2", 64'(pos), 64'd2);

    // 3: ping-pong from position 0
    mode = 2'b00;
    press(10, 12);
    press(10, 12);
    chk("pp_start", 64'(pos), 64'd0);
    mode = 2'b10;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      press(10, 12);
      chk("pp_pos", 64'(pos), 64'(exp3[i]));
    end
    chk("pp_pulses", 64'(pulses), 64'd8);

    // 4: bounce then clean hold gives one step; we=0 blocks a press
    mode = 2'b00;
    p0 = int'(pos);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      button = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
      cycle();
    end
    press(12, 12);
    chk("bounce_pulses", 64'(pulses), 64'd1);
    chk("bounce_pos", 64'(pos), 64'((p0 + 1) % N));
    p0 = int'(pos);
    pulses = 0;
    we = 1'b0;
    press(10, 12);
    chk("we0_pulses", 64'(pulses), 64'd0);
    chk("we0_pos", 64'(pos), 64'(p0));
    we = 1'b1;

    // 5: auto mode timing, we gap, button ignored
    mode = 2'b11;
    idx.delete();
    for (int i = 1; i <= 40; i++) begin
      button = (i >= 5 && i < 20) ? 1'b1 : 1'b0;
      cycle();
      if (step_pulse === 1'b1) idx.push_back(i);
    end
    chk("auto_steps", 64'(idx.size()), 64'd5);
    last = 0;
    foreach (idx[i]) begin
      chk("auto_spacing", 64'(idx[i] - last), 64'(AD));
      last = idx[i];
    end
    we = 1'b0;
    repeat (5) cycle();
    we = 1'b1;
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (first < 0 && step_pulse === 1'b1) first = i;
    end
    chk("auto_resume", 64'(first), 64'(AD));

    // 6: reset mid-debounce with button held
    mode = 2'b00;
    repeat (12) cycle();
    button = 1'b1;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    chk("rst_leds", 64'(leds), 64'd0);
    rst = 1'b0;
    cycle();
    chk("post_rst_leds", 64'(leds), 64'd1);
    chk("post_rst_pos", 64'(pos), 64'd0);
    pulses = 0;
    repeat (20) cycle();
    button = 1'b0;
    repeat (12) cycle();
    chk("held_no_step", 64'(pulses), 64'd0);
    press(10, 12);
    chk("repress_step", 64'(pulses), 64'd1);
    chk("repress_pos", 64'(pos), 64'd1);

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(49) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(29) == 0) we = ~we;
      if ($urandom_range(5) == 0) button = ~button;
      rst = ($urandom_range(399) == 0) ? 1'b1 : 1'b0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
